// File: rtl/pipeline_control.sv
// pipeline_control: instruction decode plus the control pipeline of a 5-stage MIPS core.
//   It decodes the ID-stage instruction into PC, EX, MEM and WB control bundles.
//   It also owns the ID/EX, EX/MEM and MEM/WB control registers, load-use stall,
//   branch/jump flush and the multi-cycle MUL stall.
// Ports:
//   clk_i, rst_n_i            clock (rising edge), asynchronous active-low reset
//   op_i, func_i              ID-stage opcode / function field
//   is_equal_i                ID-stage rs==rt compare result
//   id_rs_i/id_rt_i/id_rd_i   ID-stage register fields
//   pc_ctrl_o                 {redirect, jump/branch} PC mux select (combinational)
//   stall_o, flush_o          hold PC+IF/ID, clear IF/ID (combinational)
//   illegal_o                 ID holds an undefined op/func (combinational)
//   mul_busy_o                MUL still occupying EX after its first cycle
//   ex_ctrl_o, ex_wreg_o      EX {ALUop, ALUsrc, RegDst} and destination register
//   mem_ctrl_o, mem_wreg_o    MEM {MEM_cs, MEM_we} and destination register
//   wb_ctrl_o, wb_wreg_o      WB {WB_mux, Reg_we} and destination register
module pipeline_control #(
    parameter int ALUOP_W      = 3,
    parameter int REG_ADDR_W   = 5,
    parameter int MUL_CYCLES   = 3,
    parameter int BRANCH_FLUSH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [5:0]            op_i,
    input  logic [5:0]            func_i,
    input  logic                  is_equal_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    output logic [1:0]            pc_ctrl_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic                  illegal_o,
    output logic                  mul_busy_o,
    output logic [ALUOP_W+1:0]    ex_ctrl_o,
    output logic [REG_ADDR_W-1:0] ex_wreg_o,
    output logic [1:0]            mem_ctrl_o,
    output logic [REG_ADDR_W-1:0] mem_wreg_o,
    output logic [1:0]            wb_ctrl_o,
    output logic [REG_ADDR_W-1:0] wb_wreg_o
);
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b110);
    localparam logic [ALUOP_W-1:0] ALU_MUL = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b001);
    localparam int CNT_W = 4;

    logic [ALUOP_W-1:0]    w_alu;
    logic                  w_alusrc;
    logic                  w_regdst;
    logic [1:0]            w_mem;
    logic [1:0]            w_wb;
    logic [1:0]            w_pc;
    logic                  w_illegal;
    logic                  w_is_mul;
    logic                  w_reads_rt;
    logic [ALUOP_W+1:0]    w_id_ctrl;
    logic [REG_ADDR_W-1:0] w_id_wreg;
    logic                  w_mul_busy;
    logic                  w_load_use;
    logic                  w_stall;

    logic [ALUOP_W+1:0]    r_ex_ctrl;
    logic [1:0]            r_ex_mem;
    logic [1:0]            r_ex_wb;
    logic [REG_ADDR_W-1:0] r_ex_wreg;
    logic [1:0]            r_mem_ctrl;
    logic [1:0]            r_mem_wb;
    logic [REG_ADDR_W-1:0] r_mem_wreg;
    logic [1:0]            r_wb_ctrl;
    logic [REG_ADDR_W-1:0] r_wb_wreg;
    logic [CNT_W-1:0]      r_cnt;

    always_comb begin
        w_alu      = '0;
        w_alusrc   = 1'b0;
        w_regdst   = 1'b0;
        w_mem      = 2'b00;
        w_wb       = 2'b00;
        w_pc       = 2'b00;
        w_illegal  = 1'b0;
        w_is_mul   = 1'b0;
        w_reads_rt = 1'b0;
        case (op_i)
            6'b000000: begin
                w_reads_rt = 1'b1;
                w_regdst   = 1'b1;
                w_wb       = 2'b11;
                case (func_i)
                    6'b100000: w_alu = ALU_ADD;
                    6'b100010: w_alu = ALU_SUB;
                    6'b011000: begin
                        w_alu    = ALU_MUL;
                        w_is_mul = 1'b1;
                    end
                    6'b100100: w_alu = ALU_AND;
                    6'b100101: w_alu = ALU_OR;
                    default: begin
                        // undefined func: the whole bundle collapses to a bubble
                        w_illegal  = 1'b1;
                        w_reads_rt = 1'b0;
                        w_regdst   = 1'b0;
                        w_wb       = 2'b00;
                    end
                endcase
            end
            6'b001000: begin
                w_alu    = ALU_ADD;
                w_alusrc = 1'b1;
                w_wb     = 2'b11;
            end
            6'b100011: begin
                w_alu    = ALU_ADD;
                w_alusrc = 1'b1;
                w_mem    = 2'b10;
                w_wb     = 2'b01;
            end
            6'b101011: begin
                w_alu      = ALU_ADD;
                w_alusrc   = 1'b1;
                w_mem      = 2'b11;
                w_wb       = 2'b10;
                w_reads_rt = 1'b1;
            end
            6'b000010: w_pc = 2'b10;
            6'b000100: begin
                w_pc       = is_equal_i ? 2'b11 : 2'b00;
                w_reads_rt = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_id_ctrl  = {w_alu, w_alusrc, w_regdst};
    assign w_id_wreg  = w_regdst ? id_rd_i : id_rt_i;
    assign w_mul_busy = r_cnt != '0;
    // a load in EX whose result the ID instruction needs; $0 never creates a dependency
    assign w_load_use = r_ex_mem == 2'b10 && r_ex_wb[0] && r_ex_wreg != '0 &&
                        (r_ex_wreg == id_rs_i || (w_reads_rt && r_ex_wreg == id_rt_i));
    assign w_stall    = w_mul_busy | w_load_use;

    assign pc_ctrl_o  = w_stall ? 2'b00 : w_pc;
    assign flush_o    = (BRANCH_FLUSH != 0) && pc_ctrl_o[1];
    assign stall_o    = w_stall;
    assign illegal_o  = w_illegal;
    assign mul_busy_o = w_mul_busy;
    assign ex_ctrl_o  = r_ex_ctrl;
    assign ex_wreg_o  = r_ex_wreg;
    assign mem_ctrl_o = r_mem_ctrl;
    assign mem_wreg_o = r_mem_wreg;
    assign wb_ctrl_o  = r_wb_ctrl;
    assign wb_wreg_o  = r_wb_wreg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ex_ctrl  <= '0;
            r_ex_mem   <= '0;
            r_ex_wb    <= '0;
            r_ex_wreg  <= '0;
            r_mem_ctrl <= '0;
            r_mem_wb   <= '0;
            r_mem_wreg <= '0;
            r_wb_ctrl  <= '0;
            r_wb_wreg  <= '0;
            r_cnt      <= '0;
        end else begin
            r_wb_ctrl <= r_mem_wb;
            r_wb_wreg <= r_mem_wreg;
            if (w_mul_busy) begin
                // MUL keeps EX; a bubble drains into MEM behind it
                r_mem_ctrl <= '0;
                r_mem_wb   <= '0;
                r_mem_wreg <= '0;
                r_cnt      <= r_cnt - 1'b1;
            end else begin
                r_mem_ctrl <= r_ex_mem;
                r_mem_wb   <= r_ex_wb;
                r_mem_wreg <= r_ex_wreg;
                r_ex_ctrl  <= w_load_use ? '0 : w_id_ctrl;
                r_ex_mem   <= w_load_use ? '0 : w_mem;
                r_ex_wb    <= w_load_use ? '0 : w_wb;
                r_ex_wreg  <= w_load_use ? '0 : w_id_wreg;
                r_cnt      <= (!w_load_use && w_is_mul && MUL_CYCLES > 1) ? CNT_W'(MUL_CYCLES - 1) : '0;
            end
        end
    end
endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Successor to the combinational opcode/func decoder of the 5-stage MIPS core.
- Decodes the ID-stage instruction into the same PC/EX/MEM/WB control bundles.
- Also owns the ID/EX, EX/MEM and MEM/WB control pipeline registers, load-use hazard detection, branch/jump flush, and a parametrised multi-cycle MUL stall.
- Sits between the IF/ID register and the datapath pipeline registers; the datapath consumes its per-stage control outputs.

Parameters:
- ALUOP_W, 3: ALU opcode width; ALU codes are the shared lookup-table constants (ADD/SUB/MUL/AND/OR).
- REG_ADDR_W, 5: register-file address width.
- MUL_CYCLES, 3: EX occupancy of MUL in cycles; legal range 1..15; 1 means single-cycle, no stall.
- BRANCH_FLUSH, 1: 1 = flush IF/ID on taken BEQ or J; 0 = delay-slot mode, flush_o tied 0.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- op_i  in  6  ID-stage opcode.
- func_i  in  6  ID-stage function field.
- is_equal_i  in  1  ID-stage rs==rt compare result.
- id_rs_i  in  REG_ADDR_W  ID-stage rs.
- id_rt_i  in  REG_ADDR_W  ID-stage rt.
- id_rd_i  in  REG_ADDR_W  ID-stage rd.
- pc_ctrl_o  out  2  {PC_mux[1]: normal/redirect, PC_mux[0]: jump/branch}; combinational.
- stall_o  out  1  hold PC and IF/ID; combinational.
- flush_o  out  1  clear IF/ID; combinational.
- illegal_o  out  1  ID holds an undefined op/func; combinational.
- mul_busy_o  out  1  MUL occupying EX beyond its first cycle.
- ex_ctrl_o  out  ALUOP_W+2  {ALUop, ALUsrc, RegDst}; registered.
- ex_wreg_o  out  REG_ADDR_W  EX destination register.
- mem_ctrl_o  out  2  {MEM_cs, MEM_we}.
- mem_wreg_o  out  REG_ADDR_W  MEM destination register.
- wb_ctrl_o  out  2  {WB_mux (0 memory, 1 ALU), Reg_we}.
- wb_wreg_o  out  REG_ADDR_W  WB destination register.

Behaviour:
- Decode (combinational):
  - R-type op 000000: func 100000 ADD, 100010 SUB, 011000 MUL, 100100 AND, 100101 OR → EX {alu,0,1}, MEM 00, WB 11.
  - ADDI 001000: EX {ADD,1,0}, MEM 00, WB 11.
  - LW 100011: EX {ADD,1,0}, MEM 10, WB 01.
  - SW 101011: EX {ADD,1,0}, MEM 11, WB 10.
  - J 000010: pc 10, all other bundles 0.
  - BEQ 000100: pc 11 if is_equal_i else 00, all other bundles 0.
  - Anything else: all-zero bundle, illegal_o=1.
- ID destination register: id_rd_i when RegDst=1, else id_rt_i.
- Reset (rst_n_i low, asynchronous):
  - All stage registers, wreg outputs and the MUL counter clear to 0.
  - mul_busy_o=0.
  - Combinational outputs follow from the zero state; stall_o=0 unless ID decodes a hazard.
- Load-use hazard (load_use): asserted when all of the following hold.
  - EX is a load: mem_ctrl {1,0} and Reg_we=1.
  - ex_wreg_o != 0.
  - ex_wreg_o equals id_rs_i, or equals id_rt_i with the ID instruction reading rt (R-type, BEQ, SW).
- MUL counter:
  - When a MUL enters EX with MUL_CYCLES>1, the counter loads MUL_CYCLES-1.
  - mul_busy_o = (counter != 0); the counter decrements each cycle while nonzero.
- Priority and per-cycle update:
  - mul_busy: EX holds its contents, EX/MEM receives a bubble (all zero), ID is held, stall_o=1, pc_ctrl_o=00, flush_o=0.
  - Else load_use: ID/EX receives a bubble, EX/MEM and MEM/WB advance normally, stall_o=1, pc_ctrl_o=00, flush_o=0. A branch waiting in ID resolves only after the stall clears.
  - Else normal: all stages advance, ID/EX takes the decoded bundle. flush_o = BRANCH_FLUSH & pc_ctrl_o[1], for exactly the cycle the redirect is presented.
- Illegal instruction: enters the pipe as a bubble; no stall.
- Latency: ID decode appears on ex_ctrl_o 1 cycle later, on mem_ctrl_o 2 cycles later, on wb_ctrl_o 3 cycles later (plus stall cycles).
- Back-to-back MULs: the second MUL waits in ID until the first drains, then reloads the counter on its EX entry.
- A load in EX while a MUL is busy: not possible, since EX holds the MUL.
- Reset mid-MUL: the counter clears and mul_busy_o drops immediately.

Test Plan:
- ADD (op 0, func 100000, rd=5) for 1 cycle, then NOPs → ex_ctrl_o={ADD,0,1}, ex_wreg_o=5 at cycle+1; mem_ctrl_o=00 at +2; wb_ctrl_o=11, wb_wreg_o=5 at +3; stall_o never asserts.
- LW rt=3, then ADD rs=3 → stall_o=1 for exactly 1 cycle, ex_ctrl_o=0 bubble, ADD reaches EX 1 cycle late. Repeat with LW rt=0 → no stall.
- BEQ with is_equal_i=1, BRANCH_FLUSH=1 → pc_ctrl_o=11, flush_o=1 for one cycle. With is_equal_i=0 → pc_ctrl_o=00, flush_o=0. J → pc_ctrl_o=10.
- MUL with MUL_CYCLES=3, followed by ADDI → mul_busy_o high 2 cycles, stall_o high 2 cycles, mem_ctrl_o/wb_ctrl_o bubbles inserted, ADDI reaches EX on cycle 4. With MUL_CYCLES=1 → no stall.
- op 111111 → illegal_o=1, all-zero bundle propagates, no stall.
- Assert rst_n_i low during mul_busy_o=1 → all outputs and counter 0 immediately; after release, pipe restarts cleanly with the next decode.
